// File: rtl/input_debounce_filter.sv
// Debounce filter: synchronises raw_in, samples it on a prescaled tick and commits
// a level change after STABLE_COUNT agreeing samples. Optional glitch counter: INPUT_DEBOUNCE_GLITCH_CNT_EN.
module input_debounce_filter #(
  parameter int SYNC_STAGES  = 2,
  parameter int PRESCALE     = 4,
  parameter int STABLE_COUNT = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       raw_in,
  output logic       clean_out,
  output logic       rise_pulse,
  output logic       fall_pulse,
  output logic       busy
`ifdef INPUT_DEBOUNCE_GLITCH_CNT_EN
  ,
  output logic [7:0] glitch_count
`endif
);

  localparam int                 PRESC_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PRESC_W-1:0] PRESC_MAX  = PRESC_W'(PRESCALE - 1);
  localparam logic [PRESC_W-1:0] PRESC_ONE  = PRESC_W'(1);
  localparam logic [7:0]         STABLE_MAX = 8'(STABLE_COUNT);

  typedef enum logic [1:0] {
    IDLE_LOW   = 2'b00,
    CHECK_HIGH = 2'b01,
    IDLE_HIGH  = 2'b10,
    CHECK_LOW  = 2'b11
  } state_t;

  logic [SYNC_STAGES-1:0] sync_r;
  logic [PRESC_W-1:0]     presc_r;
  state_t                 state_r, state_nx_s;
  logic [7:0]             cnt_r, cnt_nx_s;
  logic                   sync_s, tick_s, glitch_s, high_s, check_s;

  assign sync_s  = sync_r[SYNC_STAGES-1];
  assign tick_s  = (presc_r == PRESC_MAX);
  assign high_s  = (state_r == IDLE_HIGH) || (state_r == CHECK_LOW);
  assign check_s = (state_r == CHECK_HIGH) || (state_r == CHECK_LOW);

  // synchroniser chain into clk
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_r <= {SYNC_STAGES{1'b0}};
    end else begin
      sync_r <= {sync_r[SYNC_STAGES-2:0], raw_in};
    end
  end

  // sample-tick prescaler
  always_ff @(posedge clk) begin
    if (reset) begin
      presc_r <= {PRESC_W{1'b0}};
    end else if (tick_s) begin
      presc_r <= {PRESC_W{1'b0}};
    end else begin
      presc_r <= presc_r + PRESC_ONE;
    end
  end

  // state and agreement-counter register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE_LOW;
      cnt_r   <= 8'd0;
    end else begin
      state_r <= state_nx_s;
      cnt_r   <= cnt_nx_s;
    end
  end

  // next-state logic; a disagreeing sample mid-check is an aborted candidate
  always_comb begin
    state_nx_s = state_r;
    cnt_nx_s   = cnt_r;
    glitch_s   = 1'b0;
    if (tick_s) begin
      case (state_r)
        IDLE_LOW: begin
          if (sync_s) begin
            if (STABLE_COUNT == 1) begin
              state_nx_s = IDLE_HIGH;
              cnt_nx_s   = 8'd0;
            end else begin
              state_nx_s = CHECK_HIGH;
              cnt_nx_s   = 8'd1;
            end
          end else begin
            state_nx_s = IDLE_LOW;
            cnt_nx_s   = 8'd0;
          end
        end
        CHECK_HIGH: begin
          if (sync_s) begin
            if (cnt_r + 8'd1 == STABLE_MAX) begin
              state_nx_s = IDLE_HIGH;
              cnt_nx_s   = 8'd0;
            end else begin
              cnt_nx_s   = cnt_r + 8'd1;
            end
          end else begin
            state_nx_s = IDLE_LOW;
            cnt_nx_s   = 8'd0;
            glitch_s   = 1'b1;
          end
        end
        IDLE_HIGH: begin
          if (!sync_s) begin
            if (STABLE_COUNT == 1) begin
              state_nx_s = IDLE_LOW;
              cnt_nx_s   = 8'd0;
            end else begin
              state_nx_s = CHECK_LOW;
              cnt_nx_s   = 8'd1;
            end
          end else begin
            state_nx_s = IDLE_HIGH;
            cnt_nx_s   = 8'd0;
          end
        end
        CHECK_LOW: begin
          if (!sync_s) begin
            if (cnt_r + 8'd1 == STABLE_MAX) begin
              state_nx_s = IDLE_LOW;
              cnt_nx_s   = 8'd0;
            end else begin
              cnt_nx_s   = cnt_r + 8'd1;
            end
          end else begin
            state_nx_s = IDLE_HIGH;
            cnt_nx_s   = 8'd0;
            glitch_s   = 1'b1;
          end
        end
        default: begin
          state_nx_s = IDLE_LOW;
          cnt_nx_s   = 8'd0;
        end
      endcase
    end else begin
      state_nx_s = state_r;
      cnt_nx_s   = cnt_r;
    end
  end

  // registered level, edge strobes and busy flag
  always_ff @(posedge clk) begin
    if (reset) begin
      clean_out  <= 1'b0;
      rise_pulse <= 1'b0;
      fall_pulse <= 1'b0;
      busy       <= 1'b0;
    end else begin
      clean_out  <= high_s;
      rise_pulse <= high_s & ~clean_out;
      fall_pulse <= ~high_s & clean_out;
      busy       <= check_s;
    end
  end

`ifdef INPUT_DEBOUNCE_GLITCH_CNT_EN
  // saturating count of aborted candidates
  always_ff @(posedge clk) begin
    if (reset) begin
      glitch_count <= 8'd0;
    end else if (glitch_s && (glitch_count != 8'hFF)) begin
      glitch_count <= glitch_count + 8'd1;
    end else begin
      glitch_count <= glitch_count;
    end
  end
`else
  logic glitch_unused_s;
  assign glitch_unused_s = glitch_s;
`endif

endmodule

// File: tb/tb_input_debounce_filter.sv
// Directed bench for input_debounce_filter: default instance (2/4/3) plus a
// fast instance (PRESCALE=1, STABLE_COUNT=2) for glitch saturation.
module tb_input_debounce_filter;

  logic clk = 1'b0;
  logic reset, raw_in, raw2;
  logic clean_out, rise_pulse, fall_pulse, busy;
  logic clean2, rise2, fall2, busy2;
`ifdef INPUT_DEBOUNCE_GLITCH_CNT_EN
  logic [7:0] glitch_count, glitch2;
`endif
  int checks_n = 0;
  int errors_n = 0;

  always #5 clk = ~clk;

  input_debounce_filter u_dut (
    .clk(clk), .reset(reset), .raw_in(raw_in), .clean_out(clean_out),
    .rise_pulse(rise_pulse), .fall_pulse(fall_pulse), .busy(busy)
`ifdef INPUT_DEBOUNCE_GLITCH_CNT_EN
    , .glitch_count(glitch_count)
`endif
  );

  input_debounce_filter #(.SYNC_STAGES(2), .PRESCALE(1), .STABLE_COUNT(2)) u_dut2 (
    .clk(clk), .reset(reset), .raw_in(raw2), .clean_out(clean2),
    .rise_pulse(rise2), .fall_pulse(fall2), .busy(busy2)
`ifdef INPUT_DEBOUNCE_GLITCH_CNT_EN
    , .glitch_count(glitch2)
`endif
  );

  task automatic check(input string tag, input int obs, input int exp);
    checks_n++;
    if (obs !== exp) begin
      errors_n++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive raw_in=raw_v (inverted again after 'hold' cycles if hold>0), watch 20 cycles.
  task automatic qualify(input string tag, input logic raw_v, input int hold,
                         input int exp_lat, input int exp_busy, input int exp_rise,
                         input int exp_fall, input int exp_end);
    int   lat = 0;
    int   nb = 0;
    int   nr = 0;
    int   nf = 0;
    int   both = 0;
    logic start;
    start  = clean_out;
    raw_in = raw_v;
    for (int i = 1; i <= 20; i++) begin
      step();
      if (i == hold) raw_in = ~raw_v;
      if (lat == 0 && clean_out !== start) lat = i;
      nb += int'(busy);
      nr += int'(rise_pulse);
      nf += int'(fall_pulse);
      both += int'(rise_pulse & fall_pulse);
    end
    check({tag, "_latency"}, lat, exp_lat);
    check({tag, "_busy_cycles"}, nb, exp_busy);
    check({tag, "_rise_cycles"}, nr, exp_rise);
    check({tag, "_fall_cycles"}, nf, exp_fall);
    check({tag, "_both_pulses"}, both, 0);
    check({tag, "_end_level"}, int'(clean_out), exp_end);
  endtask

  initial begin
    int bad;
    int lat2;
    reset  = 1'b1;
    raw_in = 1'b1;
    raw2   = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      check("reset_hold_outputs", int'({clean_out, busy, rise_pulse, fall_pulse}), 0);
    end
    reset = 1'b0;

    // Prescaler is 0 at release, so every 20-cycle window starts just after a tick.
    qualify("rise",        1'b1, 0, 13, 8, 1, 0, 1);
    qualify("glitch_high", 1'b0, 4,  0, 4, 0, 0, 1);
    qualify("fall",        1'b0, 0, 13, 8, 0, 1, 0);
    qualify("glitch_low",  1'b1, 4,  0, 4, 0, 0, 0);
`ifdef INPUT_DEBOUNCE_GLITCH_CNT_EN
    check("glitch_count_two", int'(glitch_count), 2);
`endif

    // Reset while CHECK_HIGH holds cnt=2.
    raw_in = 1'b1;
    repeat (9) step();
    check("midq_busy_before", int'(busy), 1);
    reset = 1'b1;
    step();
    check("midq_reset_outputs", int'({clean_out, busy, rise_pulse, fall_pulse}), 0);
`ifdef INPUT_DEBOUNCE_GLITCH_CNT_EN
    check("midq_glitch_cleared", int'(glitch_count), 0);
`endif
    reset = 1'b0;
    qualify("requalify", 1'b1, 0, 13, 8, 1, 0, 1);

    // 300 one-cycle pulses on the fast instance, each aborted after one sample.
    bad = 0;
    for (int p = 0; p < 300; p++) begin
      raw2 = 1'b1;
      step();
      bad += int'(clean2 | rise2);
      raw2 = 1'b0;
      repeat (4) begin
        step();
        bad += int'(clean2 | rise2);
      end
    end
    check("sat_clean_never_high", bad, 0);
`ifdef INPUT_DEBOUNCE_GLITCH_CNT_EN
    check("sat_glitch_255", int'(glitch2), 255);
    repeat (5) step();
    check("sat_glitch_stays", int'(glitch2), 255);
`endif

    // Held high on the fast instance: commits after 2 samples.
    lat2 = 0;
    raw2 = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      step();
      if (lat2 == 0 && clean2 === 1'b1) lat2 = i;
    end
    check("fast_rise_latency", lat2, 5);

    $display("CHECKS %0d ERRORS %0d", checks_n, errors_n);
    $finish;
  end

endmodule
